// File: rtl/cp0_except.sv
// cp0_except: coprocessor-0 register file plus exception arbitration for the
// MEM stage of the 5-stage MIPS pipeline.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   int_i               external interrupt lines, sampled into Cause[15:10]
//   we_i/waddr_i/wdata_i  mtc0 write from WB
//   raddr_i/rdata_o     mfc0 read (combinational, forwards a same-cycle write)
//   excflags_i          raw MEM flags: [8] syscall [9] invalid [10] trap [11] ovf [12] eret
//   inst_addr_i         PC of the MEM instruction (0 means bubble)
//   in_delayslot_i      MEM instruction sits in a branch delay slot
//   excepttype_o        resolved exception code for the pipeline controller
//   cp0_epc_o           effective EPC (eret target)
//   status_o, cause_o, epc_o, count_o, compare_o  raw register values
//   timer_int_o         Count==Compare interrupt, routed back to int_i[5]
module cp0_except #(
    parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
    parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] excflags_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    localparam logic [4:0] RegCount   = 5'd9;
    localparam logic [4:0] RegCompare = 5'd11;
    localparam logic [4:0] RegStatus  = 5'd12;
    localparam logic [4:0] RegCause   = 5'd13;
    localparam logic [4:0] RegEpc     = 5'd14;
    localparam logic [4:0] RegPrid    = 5'd15;
    localparam logic [4:0] RegConfig  = 5'd16;

    localparam logic [31:0] ExcInt  = 32'h0000_0001;
    localparam logic [31:0] ExcSys  = 32'h0000_0008;
    localparam logic [31:0] ExcInv  = 32'h0000_000a;
    localparam logic [31:0] ExcTrap = 32'h0000_000d;
    localparam logic [31:0] ExcOvf  = 32'h0000_000c;
    localparam logic [31:0] ExcEret = 32'h0000_000e;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        timer_q, timer_d;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        exc_take, exc_eret;
    logic [4:0]  exc_code;

    // Flag bits outside [12:8] carry no meaning here.
    logic unused_flags;
    assign unused_flags = ^{excflags_i[31:13], excflags_i[7:0]};

    assign wr_count   = we_i && (waddr_i == RegCount);
    assign wr_compare = we_i && (waddr_i == RegCompare);
    assign wr_status  = we_i && (waddr_i == RegStatus);
    assign wr_cause   = we_i && (waddr_i == RegCause);
    assign wr_epc     = we_i && (waddr_i == RegEpc);

    // Arbitration sees a same-cycle mtc0 as if it had already landed.
    assign eff_status = wr_status ? wdata_i : status_q;
    assign eff_cause  = wr_cause  ? wdata_i : cause_q;
    assign eff_epc    = wr_epc    ? wdata_i : epc_q;

    always_comb begin
        excepttype_o = 32'h0;
        if (!rst && (inst_addr_i != 32'h0)) begin
            if (((eff_cause[15:8] & eff_status[15:8]) != 8'h0) &&
                eff_status[0] && !eff_status[1]) begin
                excepttype_o = ExcInt;
            end else if (excflags_i[8]) begin
                excepttype_o = ExcSys;
            end else if (excflags_i[9]) begin
                excepttype_o = ExcInv;
            end else if (excflags_i[10]) begin
                excepttype_o = ExcTrap;
            end else if (excflags_i[11]) begin
                excepttype_o = ExcOvf;
            end else if (excflags_i[12]) begin
                excepttype_o = ExcEret;
            end
        end
    end

    assign cp0_epc_o = rst ? 32'h0 : eff_epc;
    assign exc_eret  = (excepttype_o == ExcEret);
    assign exc_take  = (excepttype_o != 32'h0) && !exc_eret;

    always_comb begin
        exc_code = 5'd0;
        case (excepttype_o)
            ExcSys:  exc_code = 5'd8;
            ExcInv:  exc_code = 5'd10;
            ExcTrap: exc_code = 5'd13;
            ExcOvf:  exc_code = 5'd12;
            default: exc_code = 5'd0;
        endcase
    end

    always_comb begin
        count_d   = wr_count ? wdata_i : count_q + 32'd1;
        compare_d = wr_compare ? wdata_i : compare_q;

        // Writing Compare acknowledges the timer and masks a match in that cycle.
        timer_d = timer_q;
        if (wr_compare) begin
            timer_d = 1'b0;
        end else if ((compare_q != 32'h0) && (count_q == compare_q)) begin
            timer_d = 1'b1;
        end

        status_d = status_q;
        if (wr_status) begin
            status_d[15:8] = wdata_i[15:8];
            status_d[1:0]  = wdata_i[1:0];
        end
        if (exc_take) begin
            status_d[1] = 1'b1;
        end else if (exc_eret) begin
            status_d[1] = 1'b0;
        end

        cause_d        = cause_q;
        cause_d[15:10] = int_i;
        if (wr_cause) begin
            cause_d[9:8] = wdata_i[9:8];
        end

        epc_d = wr_epc ? wdata_i : epc_q;

        // Nested exceptions keep the original EPC/BD.
        if (exc_take) begin
            cause_d[6:2] = exc_code;
            if (!eff_status[1]) begin
                cause_d[31] = in_delayslot_i;
                epc_d       = in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            status_q  <= STATUS_RESET;
            cause_q   <= 32'h0;
            epc_q     <= 32'h0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else begin
            case (raddr_i)
                RegCount:   rdata_o = count_q;
                RegCompare: rdata_o = compare_q;
                RegStatus:  rdata_o = status_q;
                RegCause:   rdata_o = cause_q;
                RegEpc:     rdata_o = epc_q;
                RegPrid:    rdata_o = PRID_VALUE;
                RegConfig:  rdata_o = CONFIG_VALUE;
                default:    rdata_o = 32'h0;
            endcase
        end
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_except.sv
module tb_cp0_except;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [31:0] excflags_i;
    logic [31:0] inst_addr_i;
    logic        in_delayslot_i;
    logic [31:0] excepttype_o;
    logic [31:0] cp0_epc_o;
    logic [31:0] status_o, cause_o, epc_o, count_o, compare_o;
    logic        timer_int_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] got, exp_v;

    localparam logic [31:0] F_SYS  = 32'h100;
    localparam logic [31:0] F_INV  = 32'h200;
    localparam logic [31:0] F_TRAP = 32'h400;
    localparam logic [31:0] F_OVF  = 32'h800;
    localparam logic [31:0] F_ERET = 32'h1000;

    cp0_except dut (
        .clk(clk), .rst(rst), .int_i(int_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .excflags_i(excflags_i),
        .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i),
        .excepttype_o(excepttype_o), .cp0_epc_o(cp0_epc_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o), .compare_o(compare_o),
        .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
    endtask

    task automatic idle();
        we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0;
        excflags_i = 32'h0; inst_addr_i = 32'h0; in_delayslot_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; int_i = 6'h0; raddr_i = 5'd0; idle();
        step(); step();
        rst = 1'b0;
        repeat (10) step();
        sb.push_back(32'd10); sb.push_back(32'h1000_0000); sb.push_back(32'h0);
        sb.push_back(32'h0048_0102); sb.push_back(32'h0000_8000); sb.push_back(32'h0);
        got = count_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_count got=%h exp=%h", got, exp_v); end
        got = status_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_status got=%h exp=%h", got, exp_v); end
        inst_addr_i = 32'h40; #1;
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_exc got=%h exp=%h", got, exp_v); end
        raddr_i = 5'd15; #1;
        got = rdata_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL read_prid got=%h exp=%h", got, exp_v); end
        raddr_i = 5'd16; #1;
        got = rdata_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL read_config got=%h exp=%h", got, exp_v); end
        raddr_i = 5'd3; #1;
        got = rdata_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL read_unmapped got=%h exp=%h", got, exp_v); end
        // PRId is read-only.
        idle(); mtc0(5'd15, 32'hdead_beef); step(); idle();
        raddr_i = 5'd15; #1;
        sb.push_back(32'h0048_0102);
        got = rdata_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL prid_ro got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401); raddr_i = 5'd12; #1;
        sb.push_back(32'h0000_0401);
        got = rdata_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL fwd_read got=%h exp=%h", got, exp_v); end
        step(); idle(); int_i = 6'b000001; step();
        inst_addr_i = 32'h100; #1;
        sb.push_back(32'h1);
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int_exc got=%h exp=%h", got, exp_v); end
        step();
        sb.push_back(32'h100); sb.push_back(32'h1000_0403); sb.push_back(32'h0000_0400);
        sb.push_back(32'h0);
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int_epc got=%h exp=%h", got, exp_v); end
        got = status_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int_status got=%h exp=%h", got, exp_v); end
        got = cause_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int_cause got=%h exp=%h", got, exp_v); end
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int_masked_exl got=%h exp=%h", got, exp_v); end
        idle(); int_i = 6'h0; step();
    endtask

    task automatic test_syscall();
        mtc0(5'd12, 32'h1000_0000); step(); idle();
        excflags_i = F_SYS; inst_addr_i = 32'h204; in_delayslot_i = 1'b1; #1;
        sb.push_back(32'h8);
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL sys_exc got=%h exp=%h", got, exp_v); end
        step(); idle();
        sb.push_back(32'h200); sb.push_back(32'h8000_0020); sb.push_back(32'h1000_0002);
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL sys_epc got=%h exp=%h", got, exp_v); end
        got = cause_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL sys_cause got=%h exp=%h", got, exp_v); end
        got = status_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL sys_status got=%h exp=%h", got, exp_v); end
        // Nested: EXL=1 keeps EPC and BD, ExcCode still updates.
        excflags_i = F_INV; inst_addr_i = 32'h400; #1;
        sb.push_back(32'ha);
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL inv_exc got=%h exp=%h", got, exp_v); end
        step(); idle();
        sb.push_back(32'h200); sb.push_back(32'h8000_0028);
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL nested_epc got=%h exp=%h", got, exp_v); end
        got = cause_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL nested_cause got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_priority();
        logic [31:0] flags [7] = '{F_OVF | F_SYS, F_INV | F_TRAP | F_OVF, F_TRAP | F_OVF | F_ERET,
                                   F_OVF | F_ERET, F_ERET, F_SYS, 32'h0};
        logic [31:0] addrs [7] = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h0, 32'h300};
        logic [31:0] exps  [7] = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(exps[i]);
            excflags_i = flags[i]; inst_addr_i = addrs[i]; #1;
            got = excepttype_o; exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL prio_%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        idle(); #1;
    endtask

    task automatic test_int_priority();
        int_i = 6'b000001; step();
        // Interrupt enabled by a same-cycle Status write beats syscall.
        mtc0(5'd12, 32'h0000_0401); excflags_i = F_SYS; inst_addr_i = 32'h700; #1;
        sb.push_back(32'h1);
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int_over_sys got=%h exp=%h", got, exp_v); end
        step(); idle(); int_i = 6'h0;
        sb.push_back(32'h700); sb.push_back(32'h1000_0403);
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int2_epc got=%h exp=%h", got, exp_v); end
        got = status_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL int2_status got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_eret();
        excflags_i = F_ERET; inst_addr_i = 32'h300; mtc0(5'd14, 32'h300); #1;
        sb.push_back(32'he); sb.push_back(32'h300);
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL eret_exc got=%h exp=%h", got, exp_v); end
        got = cp0_epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL eret_epc_fwd got=%h exp=%h", got, exp_v); end
        step(); idle();
        sb.push_back(32'h1000_0401); sb.push_back(32'h300); sb.push_back(32'h0);
        got = status_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL eret_status got=%h exp=%h", got, exp_v); end
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL eret_epc got=%h exp=%h", got, exp_v); end
        got = cause_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL eret_cause got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_back_to_back();
        mtc0(5'd13, 32'h0000_0300); excflags_i = F_SYS; inst_addr_i = 32'h604;
        in_delayslot_i = 1'b1; #1;
        sb.push_back(32'h8);
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b_exc got=%h exp=%h", got, exp_v); end
        step(); idle();
        sb.push_back(32'h8000_0320); sb.push_back(32'h600);
        got = cause_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b_cause got=%h exp=%h", got, exp_v); end
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b_epc got=%h exp=%h", got, exp_v); end
        // Status write clears EXL in the same cycle; the trap sets it back.
        mtc0(5'd12, 32'h0); excflags_i = F_TRAP; inst_addr_i = 32'h800; step(); idle();
        sb.push_back(32'h1000_0002); sb.push_back(32'h800); sb.push_back(32'h0000_0334);
        got = status_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b2_status got=%h exp=%h", got, exp_v); end
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b2_epc got=%h exp=%h", got, exp_v); end
        got = cause_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b2_cause got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_timer();
        mtc0(5'd9, 32'h1000); step();
        mtc0(5'd11, 32'h1005); step(); idle();
        sb.push_back(32'h1001);
        got = count_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL tmr_count got=%h exp=%h", got, exp_v); end
        for (int k = 1; k <= 6; k++) begin
            step();
            sb.push_back((k >= 5) ? 32'h1 : 32'h0);
            got = {31'h0, timer_int_o}; exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL tmr_cycle_%0d got=%h exp=%h", k, got, exp_v);
            end
        end
        mtc0(5'd11, 32'h2000); step(); idle();
        sb.push_back(32'h0); sb.push_back(32'h2000);
        got = {31'h0, timer_int_o}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL tmr_clear got=%h exp=%h", got, exp_v); end
        got = compare_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL tmr_compare got=%h exp=%h", got, exp_v); end
        mtc0(5'd9, 32'hffff_ffff); step(); idle();
        sb.push_back(32'hffff_ffff); sb.push_back(32'h0);
        got = count_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL cnt_max got=%h exp=%h", got, exp_v); end
        step();
        got = count_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL cnt_wrap got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_reset_mid();
        mtc0(5'd12, 32'h1000_0000); step(); idle();
        excflags_i = F_SYS; inst_addr_i = 32'h500; rst = 1'b1; #1;
        sb.push_back(32'h0); sb.push_back(32'h0);
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rst_exc got=%h exp=%h", got, exp_v); end
        got = cp0_epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rst_cp0epc got=%h exp=%h", got, exp_v); end
        step(); rst = 1'b0; excflags_i = 32'h0; #1;
        sb.push_back(32'h0); sb.push_back(32'h1000_0000); sb.push_back(32'h0);
        sb.push_back(32'h0);
        got = epc_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rst_epc got=%h exp=%h", got, exp_v); end
        got = status_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rst_status got=%h exp=%h", got, exp_v); end
        got = cause_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rst_cause got=%h exp=%h", got, exp_v); end
        got = excepttype_o; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rst_exc_after got=%h exp=%h", got, exp_v); end
        idle();
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_syscall();
        test_priority();
        test_int_priority();
        test_eret();
        test_back_to_back();
        test_timer();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/cp0_except.md
Name: cp0_except

Overview:
Coprocessor-0 register file combined with exception arbitration for the 5-stage MIPS pipeline; it sits at the MEM stage and feeds the pipeline controller.
- Collects raw exception flags and interrupt lines, and drives the resolved `excepttype_o` / `cp0_epc_o` pair that the controller turns into `flush` and `new_pc`.
- Holds Count/Compare/Status/Cause/EPC/Config/PRId, serves mfc0 reads, and accepts mtc0 writes from WB.
- Updates architectural state on exception entry and on eret.

Parameters:
PRID_VALUE, 32'h0048_0102, reset/constant value of PRId (reg 15)
CONFIG_VALUE, 32'h0000_8000, reset value of Config (reg 16, big-endian bit set)
STATUS_RESET, 32'h1000_0000, reset value of Status (reg 12, CU0=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset rst, synchronous, active-high
int_i  in  6  external hardware interrupt lines, level
we_i  in  1  mtc0 write enable from WB
waddr_i  in  5  mtc0 target register
wdata_i  in  32  mtc0 data
raddr_i  in  5  mfc0 source register
rdata_o  out  32  mfc0 read data, combinational
excflags_i  in  32  raw MEM-stage flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret
inst_addr_i  in  32  PC of instruction in MEM
in_delayslot_i  in  1  MEM instruction is in a delay slot
excepttype_o  out  32  resolved code to controller: 0x1 int, 0x8 syscall, 0xa invalid, 0xd trap, 0xc ovf, 0xe eret, 0 none
cp0_epc_o  out  32  EPC value for eret target (forwarded)
status_o / cause_o / epc_o / count_o / compare_o  out  32 each  raw register values
timer_int_o  out  1  timer interrupt, routed externally to int_i[5]

Behaviour:
- Reset (sync, rst=1 at edge): Count=0, Compare=0, Status=STATUS_RESET, Cause=0, EPC=0, Config=CONFIG_VALUE, timer_int_o=0.
  - During rst, `excepttype_o` = 0 and `cp0_epc_o` = 0.
  - Reset mid-exception aborts all pending updates.
- Count: +1 every cycle, wraps 0xFFFF_FFFF->0. An mtc0 to Count loads `wdata_i` instead of incrementing that cycle.
- Timer interrupt:
  - `timer_int_o` sets the cycle after Compare!=0 and Count==Compare.
  - Held until an mtc0 to Compare, which clears it at the same edge.
  - A Count==Compare match in that same cycle is ignored.
- Cause register fields:
  - Cause[15:10] samples `int_i` every cycle (read-only to mtc0).
  - Cause[9:8] are software-writable via mtc0.
  - Cause[31] is BD; Cause[6:2] is ExcCode.
- Writable Status fields: IM[15:8], EXL[1], IE[0]. PRId and Config are read-only; writes to them are ignored.
- Read/write forwarding: `rdata_o` returns `wdata_i` when `we_i` is high and `waddr_i`==`raddr_i`. Unmapped addresses read 0.
- Effective Status/Cause/EPC used for arbitration: the register value, replaced by `wdata_i` when `we_i` targets that register this cycle.
- Arbitration: combinational, same cycle, active only when `inst_addr_i`!=0. Priority, highest first:
  1. Interrupt: (eff Cause[15:8] & eff Status[15:8])!=0 && IE=1 && EXL=0 -> 0x1.
  2. bit8 -> 0x8.
  3. bit9 -> 0xa.
  4. bit10 -> 0xd.
  5. bit11 -> 0xc.
  6. bit12 -> 0xe.
  7. Otherwise 0.
- `cp0_epc_o` = effective EPC.
- Exception entry, at the edge when `excepttype_o` is non-eret and nonzero:
  - If EXL=0: EPC = `in_delayslot_i` ? `inst_addr_i`-4 : `inst_addr_i`; BD = `in_delayslot_i`.
  - If EXL=1: EPC and BD are left unchanged.
  - EXL is set to 1.
  - ExcCode is written: 0 int, 8 syscall, 10 invalid, 13 trap, 12 ovf.
- eret: at the edge, EXL is cleared to 0; nothing else changes.
- Simultaneous mtc0 and exception in the same cycle: exception updates win on EPC, Cause.BD/ExcCode and Status.EXL. The other mtc0 fields and registers are still written.
- Latency: `excepttype_o` is 0-cycle (combinational); register side effects land 1 cycle later.

Test Plan:
1. Reset, then run 10 cycles -> Count=10, Status=0x1000_0000, `excepttype_o`=0, `rdata_o`(raddr=15)=0x0048_0102.
2. Status=0x0000_0401 (IM2=1, IE=1), Cause IP2 via int_i[0]=1, inst_addr=0x100 -> `excepttype_o`=0x1 same cycle. Next cycle: EPC=0x100, EXL=1, ExcCode=0, and a second int no longer fires.
3. Syscall flag, inst_addr=0x204, in_delayslot=1 -> `excepttype_o`=0x8; then EPC=0x200, Cause[31]=1, ExcCode=8.
4. Overflow+syscall flags together -> 0x8 (syscall priority). Then eret with mtc0 EPC=0x300 in the same cycle -> `excepttype_o`=0xe, `cp0_epc_o`=0x300; next cycle EXL=0.
5. Compare=Count+5 via mtc0 -> `timer_int_o`=1 six cycles later. mtc0 Compare -> `timer_int_o`=0 next cycle.
6. Assert rst while an exception is pending -> next cycle EPC=0, EXL=0, `excepttype_o`=0.
